// File: rtl/fpr_add.sv
// Binary32 add/subtract, round-to-nearest-even, one registered cycle of latency.
// Define FPR_ADD_DENORM_EN for subnormal inputs/results; otherwise subnormals flush to zero.
module fpr_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        adsb,
    input  logic        in_valid,
    output logic [31:0] C,
    output logic        out_valid
);
    logic        sa, sb;
    logic [7:0]  ea_f, eb_f, ea, eb;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf;

    assign sa    = a[31];
    assign sb    = b[31] ^ adsb;
    assign ea_f  = a[30:23];
    assign eb_f  = b[30:23];
    assign fa    = a[22:0];
    assign fb    = b[22:0];
    assign a_nan = (ea_f == 8'hFF) && (fa != 23'd0);
    assign b_nan = (eb_f == 8'hFF) && (fb != 23'd0);
    assign a_inf = (ea_f == 8'hFF) && (fa == 23'd0);
    assign b_inf = (eb_f == 8'hFF) && (fb == 23'd0);
    assign ea    = (ea_f == 8'd0) ? 8'd1 : ea_f;
    assign eb    = (eb_f == 8'd0) ? 8'd1 : eb_f;
`ifdef FPR_ADD_DENORM_EN
    assign ma = {(ea_f != 8'd0), fa};
    assign mb = {(eb_f != 8'd0), fb};
`else
    assign ma = (ea_f == 8'd0) ? 24'd0 : {1'b1, fa};
    assign mb = (eb_f == 8'd0) ? 24'd0 : {1'b1, fb};
`endif

    // Raw magnitude compare orders exponent then fraction in one step.
    logic        a_big, sx, sy, eff_sub;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    assign a_big   = (a[30:0] >= b[30:0]);
    assign sx      = a_big ? sa : sb;
    assign sy      = a_big ? sb : sa;
    assign ex      = a_big ? ea : eb;
    assign ey      = a_big ? eb : ea;
    assign mx      = a_big ? ma : mb;
    assign my      = a_big ? mb : ma;
    assign d       = ex - ey;
    assign eff_sub = sx ^ sy;

    // 27-bit working format: hidden, 23 fraction, guard, round, sticky.
    logic [49:0] y_wide;
    logic [26:0] x27, y27;
    logic [27:0] sum28;
    assign y_wide = {my, 26'd0} >> d[4:0];
    assign y27    = (d > 8'd26) ? {26'd0, |my} : {y_wide[49:24], |y_wide[23:0]};
    assign x27    = {mx, 3'b000};
    assign sum28  = eff_sub ? ({1'b0, x27} - {1'b0, y27}) : ({1'b0, x27} + {1'b0, y27});

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    logic [4:0]  lzc, shamt;
    logic [26:0] n27;
    logic [9:0]  e_norm, e_fin;
    logic        flush, round_up, ovf;
    logic [24:0] mant25;
    logic [23:0] mant24;
    logic [7:0]  exp_field;
    logic [31:0] result;

    assign lzc = lzc27(sum28[26:0]);

    always_comb begin
        n27    = sum28[26:0];
        e_norm = {2'b00, ex};
        shamt  = 5'd0;
        flush  = 1'b0;
        if (sum28[27]) begin
            n27    = {sum28[27:2], sum28[1] | sum28[0]};
            e_norm = {2'b00, ex} + 10'd1;
        end else if (eff_sub) begin
            shamt = lzc;
`ifdef FPR_ADD_DENORM_EN
            // Stop normalising at the minimum exponent; the result stays subnormal.
            if ({3'b000, lzc} > (ex - 8'd1)) shamt = 5'(ex - 8'd1);
`else
            flush = ({3'b000, lzc} >= ex);
`endif
            n27    = sum28[26:0] << shamt;
            e_norm = {2'b00, ex} - {5'd0, shamt};
        end
    end

    always_comb begin
        round_up  = n27[2] & (n27[1] | n27[0] | n27[3]);
        mant25    = {1'b0, n27[26:3]} + {24'd0, round_up};
        mant24    = mant25[24] ? mant25[24:1] : mant25[23:0];
        e_fin     = mant25[24] ? (e_norm + 10'd1) : e_norm;
        // A subnormal that rounds up into the hidden bit naturally becomes exponent 1.
        exp_field = mant24[23] ? e_fin[7:0] : 8'd0;
        ovf       = mant24[23] && (e_fin >= 10'd255);
    end

    always_comb begin
        result = {sx, exp_field, mant24[22:0]};
        if (a_nan || b_nan)
            result = 32'h7FC0_0000;
        else if (a_inf && b_inf && (sa != sb))
            result = 32'h7FC0_0000;
        else if (a_inf)
            result = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            result = {sb, 8'hFF, 23'd0};
        else if (sum28 == 28'd0)
            result = eff_sub ? 32'h0000_0000 : {sx, 31'd0};
        else if (flush)
            result = {sx, 31'd0};
        else if (ovf)
            result = {sx, 8'hFF, 23'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C         <= 32'h0000_0000;
            out_valid <= 1'b0;
        end else begin
            C         <= result;
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_fpr_add.sv
// Scoreboard bench for fpr_add: directed vectors push expected results, a monitor pops and compares.
module tb_fpr_add;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        adsb, in_valid;
    logic [31:0] C;
    logic        out_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    fpr_add dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .adsb      (adsb),
        .in_valid  (in_valid),
        .C         (C),
        .out_valid (out_valid)
    );

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                         input logic [31:0] ve, input string nm);
        @(posedge clk);
        #1;
        a        = va;
        b        = vb;
        adsb     = vs;
        in_valid = 1'b1;
        exp_q.push_back(ve);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        adsb     = 1'($urandom_range(0, 1));
    endtask

    // Monitor: every out_valid cycle must match the oldest outstanding expectation.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: C=%08h with no operation outstanding", C);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (C !== e) begin
                        n_fail++;
                        $display("FAIL %s: C=%08h expected %08h", nm, C, e);
                    end else begin
                        $display("ok   %s: C=%08h", nm, C);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] denorm_exp;
`ifdef FPR_ADD_DENORM_EN
        denorm_exp = 32'h007F_FFFF;
`else
        denorm_exp = 32'h0080_0000;
`endif
        rst_n    = 1'b0;
        a        = 32'h443C_B6A8;
        b        = 32'h447D_37F0;
        adsb     = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (C !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL reset_C: C=%08h expected 00000000", C);
        end else $display("ok   reset_C: C=%08h", C);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: out_valid=%0b expected 0", out_valid);
        end else $display("ok   reset_out_valid: out_valid=%0b", out_valid);

        // Release reset with the add operands already on the bus; test 3 follows back-to-back.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(32'h44DC_F74C);
        name_q.push_back("add_exp_carry");
        issue(32'h431A_399A, 32'h431A_43D7, 1'b1, 32'hBD23_D000, "sub_negative_lz12");
        idle();
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "cancel_to_pos_zero");
        issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_minus_inf");
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow_to_inf");
        issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_even_down");
        issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, "tie_even_up");
        idle();
        idle();
        issue(32'h443C_B6A8, 32'h447D_37F0, 1'b0, 32'h44DC_F74C, "b2b_add");
        issue(32'h431A_399A, 32'h431A_43D7, 1'b1, 32'hBD23_D000, "b2b_sub");
        issue(32'h0080_0000, 32'h0000_0001, 1'b1, denorm_exp,   "subnormal_sub");
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "one_plus_one");
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, "three_minus_one");
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "negzero_plus_negzero");
        issue(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, "poszero_plus_negzero");
        issue(32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_operand");
        issue(32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, "inf_minus_finite");
        issue(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, "finite_minus_inf");
        issue(32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, "add_opposite_cancel");
        idle();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_results: outstanding=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
